target2dir: RTL and testbench

Tracking front-end for the eye servos. Accepts one target coordinate per vision frame over a valid/ready handshake and compares it against the image centre with a deadband. Converts the error into timed, mutually exclusive direction levels (`left_dir`, `right_dir`, `up_dir`, `down_dir`) that drive the eye controller's direction inputs directly. Declares the target lost after a configurable number of 1 kHz ticks without a found frame.

---
 rtl/target2dir.sv | 154 +++++++++++++++
 tb/tb_target2dir.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target2dir.sv
// Vision-target tracking front-end: turns one accepted target coordinate per frame
// into timed, mutually exclusive direction levels and declares the target lost after a tick timeout.
module target2dir #(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned CENTER_X   = 320,
  parameter int unsigned CENTER_Y   = 240,
  parameter int unsigned DEADBAND   = 16,
  parameter int unsigned HOLD_SHIFT = 3,
  parameter int unsigned MAX_HOLD   = 63,
  parameter int unsigned LOST_TICKS = 500
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               tick,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic               tgt_found,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  output logic               left_dir,
  output logic               right_dir,
  output logic               up_dir,
  output logic               down_dir,
  output logic               lost
);

  localparam int unsigned     TW     = $clog2(LOST_TICKS + 1);
  localparam logic [TW-1:0]   LOST_C = TW'(LOST_TICKS);
  localparam logic [TW-1:0]   TONE_C = TW'(1);
  localparam logic [COORD_W:0] CX_C  = (COORD_W + 1)'(CENTER_X);
  localparam logic [COORD_W:0] CY_C  = (COORD_W + 1)'(CENTER_Y);
  localparam logic [COORD_W:0] DB_C  = (COORD_W + 1)'(DEADBAND);
  localparam logic [COORD_W:0] ONE_C = (COORD_W + 1)'(1);
  localparam logic [COORD_W:0] MXW_C = (COORD_W + 1)'(MAX_HOLD);
  localparam logic [7:0]       MX8_C = 8'(MAX_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOST} state_e;

  state_e             state_q, state_d;
  logic               comp_q, comp_d;
  logic               found_q, found_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         cntx_q, cntx_d, cnty_q, cnty_d;
  logic               negx_q, negx_d, negy_q, negy_d;
  logic               left_q, left_d, right_q, right_d, up_q, up_d, down_q, down_d;
  logic               lost_q, lost_d;
  logic               acc;
  logic [COORD_W:0]   err_x, err_y;

  // Error is two's complement in COORD_W+1 bits; the hold is the saturated,
  // shifted excess over the deadband plus one.
  function automatic logic [7:0] hold_of(input logic [COORD_W:0] err);
    logic [COORD_W:0] mag;
    logic [COORD_W:0] over;
    mag = err[COORD_W] ? ('0 - err) : err;
    if (mag <= DB_C) return '0;
    over = ((mag - DB_C) >> HOLD_SHIFT) + ONE_C;
    if (over >= MXW_C) return MX8_C;
    return 8'(over);
  endfunction

  always_comb begin
    acc     = tgt_valid & ~comp_q;
    comp_d  = acc;
    found_d = found_q;
    x_d     = x_q;
    y_d     = y_q;
    if (acc) begin
      found_d = tgt_found;
      x_d     = tgt_x;
      y_d     = tgt_y;
    end

    err_x = {1'b0, x_q} - CX_C;
    err_y = {1'b0, y_q} - CY_C;

    timer_d = timer_q;
    if (state_q == S_TRACK && tick && timer_q != LOST_C) timer_d = timer_q + TONE_C;
    if (comp_q && found_q) timer_d = '0;

    state_d = state_q;
    if (state_q == S_TRACK && timer_d == LOST_C) state_d = S_LOST;
    if (comp_q && found_q) state_d = S_TRACK;

    cntx_d = cntx_q;
    cnty_d = cnty_q;
    negx_d = negx_q;
    negy_d = negy_q;
    if (tick && cntx_q != '0) cntx_d = cntx_q - 8'd1;
    if (tick && cnty_q != '0) cnty_d = cnty_q - 8'd1;
    if (state_q == S_TRACK && state_d == S_LOST) begin
      cntx_d = '0;
      cnty_d = '0;
    end
    // The compute-stage load overrides any same-edge tick decrement.
    if (comp_q) begin
      cntx_d = found_q ? hold_of(err_x) : '0;
      cnty_d = found_q ? hold_of(err_y) : '0;
      negx_d = err_x[COORD_W];
      negy_d = err_y[COORD_W];
    end

    left_d  = (state_d == S_TRACK) && (cntx_d != '0) &&  negx_d;
    right_d = (state_d == S_TRACK) && (cntx_d != '0) && !negx_d;
    up_d    = (state_d == S_TRACK) && (cnty_d != '0) &&  negy_d;
    down_d  = (state_d == S_TRACK) && (cnty_d != '0) && !negy_d;
    lost_d  = (state_d == S_LOST);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      comp_q  <= 1'b0;
      found_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      timer_q <= '0;
      cntx_q  <= '0;
      cnty_q  <= '0;
      negx_q  <= 1'b0;
      negy_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      found_q <= found_d;
      x_q     <= x_d;
      y_q     <= y_d;
      timer_q <= timer_d;
      cntx_q  <= cntx_d;
      cnty_q  <= cnty_d;
      negx_q  <= negx_d;
      negy_q  <= negy_d;
      left_q  <= left_d;
      right_q <= right_d;
      up_q    <= up_d;
      down_q  <= down_d;
      lost_q  <= lost_d;
    end
  end

  assign tgt_ready = ~comp_q;
  assign left_dir  = left_q;
  assign right_dir = right_q;
  assign up_dir    = up_q;
  assign down_dir  = down_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_target2dir.sv
// Scoreboard bench for target2dir: expected hold lengths are queued per frame and
// compared against the number of ticks each direction output stays high.
module tb_target2dir;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       tick = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic       tgt_found = 1'b0;
  logic [9:0] tgt_x = '0;
  logic [9:0] tgt_y = '0;
  logic       left_dir, right_dir, up_dir, down_dir, lost;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int l;
    int r;
    int u;
    int d;
  } exp_t;

  exp_t sb_q[$];

  target2dir #(
    .COORD_W(10), .CENTER_X(320), .CENTER_Y(240), .DEADBAND(16),
    .HOLD_SHIFT(3), .MAX_HOLD(63), .LOST_TICKS(500)
  ) dut (
    .clk(clk), .nrst(nrst), .tick(tick),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_found(tgt_found),
    .tgt_x(tgt_x), .tgt_y(tgt_y),
    .left_dir(left_dir), .right_dir(right_dir), .up_dir(up_dir), .down_dir(down_dir),
    .lost(lost)
  );

  always #5 clk = ~clk;

  function automatic int hold_model(input int v, input int c);
    int e, a, h;
    e = v - c;
    a = (e < 0) ? -e : e;
    if (a <= 16) return 0;
    h = ((a - 16) >> 3) + 1;
    if (h > 63) h = 63;
    return h;
  endfunction

  function automatic exp_t frame_model(input bit found, input int x, input int y);
    exp_t e;
    int hx, hy;
    hx  = found ? hold_model(x, 320) : 0;
    hy  = found ? hold_model(y, 240) : 0;
    e.l = (x < 320) ? hx : 0;
    e.r = (x > 320) ? hx : 0;
    e.u = (y < 240) ? hy : 0;
    e.d = (y > 240) ? hy : 0;
    return e;
  endfunction

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one frame with ready high; returns in the cycle after the accept edge.
  task automatic send_frame(input bit found, input int x, input int y);
    tgt_valid = 1'b1;
    tgt_found = found;
    tgt_x     = 10'(x);
    tgt_y     = 10'(y);
    sb_q.push_back(frame_model(found, x, y));
    cyc();
    tgt_valid = 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  // Counts, per output, how many ticks it stays high until all outputs are low.
  task automatic measure(output int cl, output int cr, output int cu, output int cd,
                         output bit to, output bit ov);
    bit done;
    cl = 0; cr = 0; cu = 0; cd = 0; ov = 1'b0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!(left_dir | right_dir | up_dir | down_dir)) begin
        done = 1'b1;
      end else begin
        if ((left_dir && right_dir) || (up_dir && down_dir)) ov = 1'b1;
        cl += int'(left_dir);
        cr += int'(right_dir);
        cu += int'(up_dir);
        cd += int'(down_dir);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
      end
    end
    to = !done;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tgt_valid = 1'b1; tgt_found = 1'b1; tgt_x = 10'd600; tgt_y = 10'd240;
    cyc(); cyc();
    tgt_valid = 1'b0;
    n_cmp++; if (tgt_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", tgt_ready); end
    n_cmp++; if ({left_dir, right_dir, up_dir, down_dir, lost} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outs got=%b want=00000", {left_dir, right_dir, up_dir, down_dir, lost}); end
    nrst = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++; if ({left_dir, right_dir, up_dir, down_dir, lost} !== 5'b0) begin
      n_bad++; $display("FAIL reset_frame_dropped got=%b want=00000", {left_dir, right_dir, up_dir, down_dir, lost}); end
  endtask

  task automatic test_left();
    exp_t e; int cl, cr, cu, cd; bit to, ov;
    send_frame(1'b1, 100, 240);
    n_cmp++; if (tgt_ready !== 1'b0) begin n_bad++; $display("FAIL left_ready_n1 got=%b want=0", tgt_ready); end
    n_cmp++; if (left_dir !== 1'b0) begin n_bad++; $display("FAIL left_early got=%b want=0", left_dir); end
    cyc();
    n_cmp++; if (tgt_ready !== 1'b1) begin n_bad++; $display("FAIL left_ready_n2 got=%b want=1", tgt_ready); end
    n_cmp++; if (left_dir !== 1'b1) begin n_bad++; $display("FAIL left_rise got=%b want=1", left_dir); end
    e = sb_q.pop_front();
    measure(cl, cr, cu, cd, to, ov);
    n_cmp++; if (to || ov) begin n_bad++; $display("FAIL left_bound timeout=%b overlap=%b want=0/0", to, ov); end
    n_cmp++; if (cl !== e.l) begin n_bad++; $display("FAIL left_hold got=%0d want=%0d", cl, e.l); end
    n_cmp++; if ({cr, cu, cd} !== {e.r, e.u, e.d}) begin
      n_bad++; $display("FAIL left_others got=%0d/%0d/%0d want=%0d/%0d/%0d", cr, cu, cd, e.r, e.u, e.d); end
  endtask

  task automatic test_deadband();
    exp_t e; int cl, cr, cu, cd; bit to, ov;
    send_frame(1'b1, 330, 400);
    cyc();
    e = sb_q.pop_front();
    measure(cl, cr, cu, cd, to, ov);
    n_cmp++; if (to || ov) begin n_bad++; $display("FAIL db_bound timeout=%b overlap=%b want=0/0", to, ov); end
    n_cmp++; if ({cl, cr} !== {e.l, e.r}) begin n_bad++; $display("FAIL db_x got=%0d/%0d want=%0d/%0d", cl, cr, e.l, e.r); end
    n_cmp++; if (cd !== e.d || cu !== e.u) begin n_bad++; $display("FAIL db_down got=%0d/%0d want=%0d/%0d", cd, cu, e.d, e.u); end
  endtask

  task automatic test_cap();
    exp_t e; int cl, cr, cu, cd; bit to, ov;
    send_frame(1'b1, 1023, 0);
    cyc();
    e = sb_q.pop_front();
    measure(cl, cr, cu, cd, to, ov);
    n_cmp++; if (to || ov) begin n_bad++; $display("FAIL cap_bound timeout=%b overlap=%b want=0/0", to, ov); end
    n_cmp++; if (cr !== e.r || cl !== e.l) begin n_bad++; $display("FAIL cap_right got=%0d/%0d want=%0d/%0d", cr, cl, e.r, e.l); end
    n_cmp++; if (cu !== e.u || cd !== e.d) begin n_bad++; $display("FAIL cap_up got=%0d/%0d want=%0d/%0d", cu, cd, e.u, e.d); end
  endtask

  task automatic test_retarget();
    exp_t e; int cl, cr, cu, cd; bit to, ov;
    send_frame(1'b1, 100, 240);
    cyc();
    pulse_ticks(5);
    e = sb_q.pop_front();
    n_cmp++; if (left_dir !== (e.l > 5)) begin n_bad++; $display("FAIL retgt_pre got=%b want=%b", left_dir, e.l > 5); end
    send_frame(1'b1, 600, 240);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_cmp++; if ({left_dir, right_dir} !== 2'b01) begin
      n_bad++; $display("FAIL retgt_swap got=%b want=01", {left_dir, right_dir}); end
    e = sb_q.pop_front();
    measure(cl, cr, cu, cd, to, ov);
    n_cmp++; if (to || ov) begin n_bad++; $display("FAIL retgt_bound timeout=%b overlap=%b want=0/0", to, ov); end
    n_cmp++; if (cr !== e.r || cl !== e.l) begin n_bad++; $display("FAIL retgt_hold got=%0d/%0d want=%0d/%0d", cr, cl, e.r, e.l); end
  endtask

  task automatic test_lost();
    exp_t e; int cl, cr, cu, cd; bit to, ov;
    send_frame(1'b1, 100, 240);
    cyc();
    void'(sb_q.pop_front());
    send_frame(1'b0, 700, 10);
    cyc();
    e = sb_q.pop_front();
    n_cmp++; if ({left_dir, right_dir, up_dir, down_dir} !== {e.l != 0, e.r != 0, e.u != 0, e.d != 0}) begin
      n_bad++; $display("FAIL lost_nofound_outs got=%b want=0000", {left_dir, right_dir, up_dir, down_dir}); end
    for (int t = 1; t <= 500; t++) begin
      if (t % 100 == 50) begin
        send_frame(1'b0, 20, 20);
        cyc();
        void'(sb_q.pop_front());
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (t == 499) begin
        n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL lost_early got=%b want=0", lost); end
      end
      if (t == 500) begin
        n_cmp++; if (lost !== 1'b1) begin n_bad++; $display("FAIL lost_rise got=%b want=1", lost); end
        n_cmp++; if ({left_dir, right_dir, up_dir, down_dir} !== 4'b0) begin
          n_bad++; $display("FAIL lost_outs got=%b want=0000", {left_dir, right_dir, up_dir, down_dir}); end
      end
      cyc();
    end
    send_frame(1'b1, 100, 240);
    n_cmp++; if (lost !== 1'b1) begin n_bad++; $display("FAIL lost_hold_n1 got=%b want=1", lost); end
    cyc();
    n_cmp++; if ({lost, left_dir} !== 2'b01) begin n_bad++; $display("FAIL lost_recover got=%b want=01", {lost, left_dir}); end
    e = sb_q.pop_front();
    measure(cl, cr, cu, cd, to, ov);
    n_cmp++; if (to || cl !== e.l) begin n_bad++; $display("FAIL lost_rehold got=%0d want=%0d timeout=%b", cl, e.l, to); end
  endtask

  task automatic test_back_to_back();
    int xs[4];
    exp_t e; int cl, cr, cu, cd; bit to, ov;
    xs[0] = 100; xs[1] = 600; xs[2] = 50; xs[3] = 400;
    tgt_valid = 1'b1; tgt_found = 1'b1; tgt_x = 10'(xs[0]); tgt_y = 10'd240;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (tgt_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_hi[%0d] got=%b want=1", k, tgt_ready); end
      cyc();
      n_cmp++; if (tgt_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_lo[%0d] got=%b want=0", k, tgt_ready); end
      if (k < 3) tgt_x = 10'(xs[k + 1]);
      else tgt_valid = 1'b0;
      cyc();
      e = frame_model(1'b1, xs[k], 240);
      n_cmp++; if ({left_dir, right_dir} !== {e.l != 0, e.r != 0}) begin
        n_bad++; $display("FAIL b2b_dir[%0d] got=%b want=%b", k, {left_dir, right_dir}, {e.l != 0, e.r != 0}); end
    end
    sb_q.push_back(frame_model(1'b1, xs[3], 240));
    e = sb_q.pop_front();
    measure(cl, cr, cu, cd, to, ov);
    n_cmp++; if (to || cr !== e.r || cl !== e.l) begin
      n_bad++; $display("FAIL b2b_hold got=%0d/%0d want=%0d/%0d timeout=%b", cr, cl, e.r, e.l, to); end
  endtask

  task automatic test_reset_mid();
    send_frame(1'b1, 100, 240);
    cyc();
    void'(sb_q.pop_front());
    pulse_ticks(3);
    n_cmp++; if (left_dir !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got=%b want=1", left_dir); end
    nrst = 1'b0;
    cyc();
    n_cmp++; if ({tgt_ready, left_dir, right_dir, up_dir, down_dir, lost} !== 6'b100000) begin
      n_bad++; $display("FAIL rmid_hold got=%b want=100000", {tgt_ready, left_dir, right_dir, up_dir, down_dir, lost}); end
    nrst = 1'b1;
    cyc();
    send_frame(1'b1, 600, 240);
    void'(sb_q.pop_front());
    nrst = 1'b0;
    cyc();
    n_cmp++; if ({tgt_ready, right_dir} !== 2'b10) begin
      n_bad++; $display("FAIL rmid_compute got=%b want=10", {tgt_ready, right_dir}); end
    nrst = 1'b1;
    cyc(); cyc();
    n_cmp++; if ({right_dir, lost} !== 2'b00) begin
      n_bad++; $display("FAIL rmid_dropped got=%b want=00", {right_dir, lost}); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_left();
    test_deadband();
    test_cap();
    test_retarget();
    test_lost();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
